// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width, M-extension op codes, the
// multiply/divide FSM states and the writeback result-select encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 codes as presented on the op input.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_ITER = 2'b01,
        DIV_ITER = 2'b10,
        FINISH   = 2'b11
    } muldiv_state_e;

    // Writeback result-select codes; the multiply/divide unit is WB_MULDIV.
    typedef enum logic [1:0] {
        WB_ALU    = 2'b00,
        WB_LOAD   = 2'b01,
        WB_MULDIV = 2'b10
    } wb_sel_e;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final result select for the multiply/divide unit. The iteration works on
// operand magnitudes; this block restores the sign and picks the field
// (product low/high word, quotient or remainder) that the op asks for.
module muldiv_sign_fix
    import riscv_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [2*XLEN-1:0] raw,      // {product} or {remainder, quotient}
    input  logic              neg_res,  // negate product / quotient
    input  logic              neg_rem,  // negate remainder
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // Negate the magnitude results and choose the field for this op.
    always_comb begin
        prod_fix = neg_res ? -raw : raw;
        quo_fix  = cond_neg(raw[XLEN-1:0], neg_res);
        rem_fix  = cond_neg(raw[2*XLEN-1:XLEN], neg_rem);
        case (muldiv_op_e'(op))
            MD_MUL:                        result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               result = quo_fix;
            default:                       result = rem_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One bit per cycle: shift-add for
// multiplies, restoring division for divides, both on operand magnitudes
// with the sign applied when the result is registered.
//
// Handshake: start is sampled only in IDLE (and only when flush is low);
// the accepting edge latches op/a/b. busy stays high through the XLEN
// iterate cycles and drops on the done cycle. done is a one-cycle pulse and
// result is valid on it and held until the next accepted start. Requests
// made while busy or on the done cycle are dropped, not queued. Divide
// special cases skip iteration and pulse done the cycle after accept.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    muldiv_state_e     state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;      // {hi, multiplier} or {remainder, dividend/quotient}
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_res_q;
    logic              neg_rem_q;

    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special;
    logic [2*XLEN-1:0] acc_load;

    // Decode the incoming request: signedness, magnitudes, special cases.
    always_comb begin
        is_div      = op[2];
        a_signed    = is_div ? ~op[0] : (op[1:0] != 2'b11);
        b_signed    = is_div ? ~op[0] : ~op[1];
        sign_a      = a_signed & a[XLEN-1];
        sign_b      = b_signed & b[XLEN-1];
        mag_a       = cond_neg(a, sign_a);
        mag_b       = cond_neg(b, sign_b);
        div_by_zero = is_div && (b == '0);
        div_ovf     = is_div && ~op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special     = div_by_zero | div_ovf;
        // Special cases preload {remainder, quotient} so the normal
        // finish path (with no negation) yields the architected value.
        if (div_by_zero) begin
            acc_load = {a, {XLEN{1'b1}}};
        end else if (div_ovf) begin
            acc_load = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
        end else if (is_div) begin
            acc_load = {{XLEN{1'b0}}, mag_a};
        end else begin
            acc_load = {{XLEN{1'b0}}, mag_b};
        end
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    // One iteration step of each datapath.
    always_comb begin
        // Shift-add: add the multiplicand into the high half when the
        // current multiplier bit is set, then shift the whole register right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        // Restoring divide: trial subtract the divisor from the partial
        // remainder extended by the next dividend bit. The true difference
        // is always below the divisor, so the low XLEN bits are exact.
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
    end

    logic [2*XLEN-1:0] acc_fin;
    logic [2:0]        fix_op;
    logic              fix_neg_res;
    logic              fix_neg_rem;
    logic [XLEN-1:0]   fin_result;

    // Value the accumulator takes on this edge; on the finishing edge it is
    // the raw result, so the signed result is registered together with done.
    always_comb begin
        fix_op      = op_q;
        fix_neg_res = neg_res_q;
        fix_neg_rem = neg_rem_q;
        case (state)
            IDLE: begin
                acc_fin     = acc_load;
                fix_op      = op;
                fix_neg_res = 1'b0;
                fix_neg_rem = 1'b0;
            end
            MUL_ITER: acc_fin = mul_next;
            DIV_ITER: acc_fin = div_next;
            default:  acc_fin = acc_q;
        endcase
    end

    muldiv_sign_fix u_sign_fix (
        .op      (fix_op),
        .raw     (acc_fin),
        .neg_res (fix_neg_res),
        .neg_rem (fix_neg_rem),
        .result  (fin_result)
    );

    // Control FSM, iteration counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        op_q      <= op;
                        opnd_q    <= is_div ? mag_b : mag_a;
                        acc_q     <= acc_fin;
                        cnt_q     <= CNT_W'(XLEN);
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        if (special) begin
                            state  <= FINISH;
                            result <= fin_result;
                            done   <= 1'b1;
                        end else begin
                            state <= is_div ? DIV_ITER : MUL_ITER;
                            busy  <= 1'b1;
                        end
                    end
                end
                MUL_ITER, DIV_ITER: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc_q <= acc_fin;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state  <= FINISH;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= fin_result;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed operations with known answers, a dropped
// start during busy, flush, asynchronous reset, then random operations
// scored against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op_i),
        .a      (a_i),
        .b      (b_i),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Reference model straight from the RV32M arithmetic rules.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     p;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'h0, x};
        uy  = {32'h0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sx / sy; return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Driver: present one request for one cycle and queue its expected result.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp);
        @(posedge clk); #1;
        start = 1'b1; op_i = o; a_i = x; b_i = y;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done with a cycle bound; check latency, busy span, result and
    // the single-cycle pulse. poke>0 raises a competing start on that cycle.
    task automatic wait_done(input string tag, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int poke);
        int          n;
        int          busy_cnt;
        bit          got;
        bit          spec;
        logic [31:0] exp;
        busy_cnt = 0;
        got      = 1'b0;
        spec     = o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke != 0 && n == poke) begin
                start = 1'b1; op_i = 3'd0; a_i = 32'd5; b_i = 32'd6;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ":done_seen"}, {31'b0, got}, 32'd1);
        check({tag, ":latency"}, 32'(n), spec ? 32'd1 : 32'd33);
        check({tag, ":busy_cycles"}, 32'(busy_cnt), spec ? 32'd0 : 32'd32);
        exp = exp_q.pop_front();
        check({tag, ":result"}, result, exp);
        last_res = exp;
        @(negedge clk);
        check({tag, ":done_single"}, {31'b0, done}, 32'd0);
        check({tag, ":result_held"}, result, exp);
    endtask

    logic [2:0]  d_op[10]  = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
    logic [31:0] d_a[10]   = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20,
                               32'h1234, 32'h1234, 32'h8000_0000};
    logic [31:0] d_b[10]   = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'd3, 32'd3, 32'd3,
                               32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] d_exp[10] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h0000_0006, 32'hFFFF_FFFA, 32'hFFFF_FFFE,
                               32'd6, 32'd2, 32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000};

    // Directed and random sequence
    initial begin
        logic [31:0] prior;
        bit          done_seen;
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op_i = 3'd0; a_i = '0; b_i = '0; last_res = '0;
        repeat (3) @(negedge clk);
        check("reset:busy", {31'b0, busy}, 32'd0);
        check("reset:done", {31'b0, done}, 32'd0);
        check("reset:result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(d_op[i], d_a[i], d_b[i], d_exp[i]);
            wait_done($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], 0);
        end

        // Competing start during busy must be dropped, not queued.
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("ignore", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        repeat (3) @(negedge clk);
        check("ignore:idle_after", {31'b0, busy}, 32'd0);
        check("ignore:result_kept", result, 32'h8000_0000);

        // Flush at T+10 of a DIV, then a new request at T+12.
        prior = last_res;
        @(posedge clk); #1;
        start = 1'b1; op_i = 3'd4; a_i = 32'hFFFF_FF9C; b_i = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        done_seen = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
            if (n == 10) flush = 1'b1;
            if (n == 11) begin
                flush = 1'b0;
                check("flush:busy_low", {31'b0, busy}, 32'd0);
            end
        end
        check("flush:no_done", {31'b0, done_seen}, 32'd0);
        check("flush:result_kept", result, prior);
        issue(3'd5, 32'd1000, 32'd7, 32'd142);
        wait_done("after_flush", 3'd5, 32'd1000, 32'd7, 0);

        // Asynchronous reset mid-operation.
        @(posedge clk); #1;
        start = 1'b1; op_i = 3'd0; a_i = 32'h0001_2345; b_i = 32'h0000_0777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst:busy", {31'b0, busy}, 32'd0);
        check("async_rst:done", {31'b0, done}, 32'd0);
        check("async_rst:result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        issue(3'd0, 32'd5, 32'd6, 32'd30);
        wait_done("post_rst_mul", 3'd0, 32'd5, 32'd6, 0);

        // Random operations, biased towards divide corner cases.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 9))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 15));
                3: rx = 32'($urandom_range(0, 100));
                default: ;
            endcase
            issue(ro, rx, ry, ref_model(ro, rx, ry));
            wait_done($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits in execute and feeds the writeback result-select multiplexer (the ALU and load-data paths are the other inputs).
- Accepts one operation per start pulse and computes it serially, one bit per cycle.
- Holds busy so the control path stalls PC and register write.
- Pulses done with a stable result, which writeback selects on the done cycle.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand, captured on accepted start
- b  input  XLEN  rs2 operand, captured on accepted start
- flush  input  1  abort any in-flight operation
- busy  output  1  high from the cycle after accept until done (inclusive of iterate states)
- done  output  1  single-cycle pulse, result valid
- result  output  XLEN  final value; held until next accepted start

Behaviour:
- Reset (rst_n low, any time, including mid-operation): state IDLE; busy=0; done=0; result=0; all internal registers 0. Takes effect asynchronously. Releases synchronously to clk.
- States: IDLE, MUL_ITER, DIV_ITER, FINISH.
- IDLE + start (cycle T):
  - Latch op, a, b.
  - Compute operand magnitudes and result sign.
  - Load counter = XLEN.
  - Go to MUL_ITER (op[2]=0) or DIV_ITER (op[2]=1).
  - Exception: a divide special case goes directly to FINISH.
- MUL_ITER: shift-add over the 2*XLEN-bit product register, one multiplier bit per cycle. Counter decrements; at 1, go to FINISH.
- DIV_ITER: restoring division, one quotient bit per cycle, using a XLEN+1-bit trial subtract. Counter decrements; at 1, go to FINISH.
- FINISH:
  - Apply sign correction (two's complement negate of the 2*XLEN product or of quotient/remainder).
  - Register result; done=1 for exactly this cycle; busy=0.
  - Next state IDLE.
- Latency, normal ops: start at T, busy high T+1..T+XLEN, done at T+XLEN+1 (T+33 for XLEN=32).
- Latency, special cases: done at T+1; busy never asserts.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Divide by zero (b=0): quotient = all ones; remainder = a. Applies to signed and unsigned.
- Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- start while busy or in FINISH is ignored and not queued. The control path must hold start low until done.
- start and done in the same cycle: done completes; start is ignored (state is FINISH, not IDLE).
- flush:
  - In any non-IDLE state: synchronous return to IDLE next edge; no done pulse; result unchanged.
  - In IDLE with start: flush wins and the request is dropped.
- result changes only in FINISH (and on reset). No X on outputs at any time after reset.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN constant.
  - muldiv_op_e enum of the eight funct3 codes.
  - muldiv_state_e enum (IDLE, MUL_ITER, DIV_ITER, FINISH).
- The writeback select encoding used by the result multiplexer also lives in riscv_pkg; this unit's output is selected with code 2'b10.
- One natural sub-module: muldiv_sign_fix, a combinational negate/select of the final result from raw product/quotient/remainder, sign flags and op.
- FSM, counter and iteration datapath stay in muldiv_unit.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at T+33, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU same operands -> 0x00000006.
- DIV a=-20, b=3 -> result=0xFFFFFFFA (-6); REM same operands -> 0xFFFFFFFE (-2); DIVU a=20, b=3 -> 6; REMU same operands -> 2.
- DIVU a=0x1234, b=0 -> done at T+1, result=0xFFFFFFFF; REM a=0x1234, b=0 -> 0x1234; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+1, busy never high.
- Start MULHSU a=0x80000000, b=0xFFFFFFFF -> result=0x80000000. During busy, assert start with a different op -> ignored, result unchanged by the second request.
- Start DIV, assert flush at T+10 -> busy low from T+11, no done pulse, result keeps prior value. New start at T+12 -> completes normally at T+45.
- Start MUL, drive rst_n low at T+5 between clock edges -> busy/done/result go to 0 immediately (async). After release, a new MUL 5x6 -> result=30.
